// File: rtl/id_pkg.sv
// Shared types and helpers for the ID-to-decimal digit streamer.
package id_pkg;

   localparam int BCD_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      EMIT    = 2'd2
   } state_t;

   // Decimal digits needed for a width-bit unsigned value: ceil(width * log10(2)).
   function automatic int digits_for_width(input int width);
      return (width * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble adjust: add 3 to any BCD nibble of 5 or more before the shift.
module bcd_add3
   import id_pkg::*;
(
   input  logic [BCD_W-1:0] nibble,
   output logic [BCD_W-1:0] adjusted
);

   assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/id_digit_streamer.sv
// Serial double-dabble conversion of an unsigned ID, streamed out MSD first over valid/ready.
// Define ID_ZERO_SUPPRESS_EN to skip leading zero digits (at least one digit is always sent).
module id_digit_streamer
   import id_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      id_in,
   output logic                  busy,
   output logic [BCD_W-1:0]      digit,
   output logic                  digit_valid,
   input  logic                  digit_ready,
   output logic                  digit_last,
   output logic                  done
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(DIGITS - 1);

   if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
      $error("id_digit_streamer: WIDTH must be within 4..64");
   end
   if (DIGITS < digits_for_width(WIDTH)) begin : g_bad_digits
      $error("id_digit_streamer: DIGITS too small for WIDTH");
   end

   state_t                        state;
   logic [WIDTH-1:0]              shift_reg;
   logic [WIDTH-1:0]              shift_next;
   logic [DIGITS-1:0][BCD_W-1:0]  bcd_reg;
   logic [DIGITS-1:0][BCD_W-1:0]  bcd_adj;
   logic [DIGITS-1:0][BCD_W-1:0]  bcd_next;
   logic [CNT_W-1:0]              bit_cnt;
   logic [IDX_W-1:0]              idx;
   logic [IDX_W-1:0]              idx_entry;
   logic                          done_reg;
   logic                          xfer;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_add3 u_add3 (
         .nibble   (bcd_reg[g]),
         .adjusted (bcd_adj[g])
      );
   end

   assign {bcd_next, shift_next} = {bcd_adj, shift_reg} << 1;

   // Starting digit index, computed from the final BCD value during the last convert cycle
   // so that leading-zero skipping costs no extra cycle.
   always_comb begin
      idx_entry = IDX_TOP;
`ifdef ID_ZERO_SUPPRESS_EN
      idx_entry = '0;
      for (int i = 1; i < DIGITS; i++) begin
         if (bcd_next[i] != '0) idx_entry = IDX_W'(i);
      end
`endif
   end

   assign busy        = (state != IDLE);
   assign digit_valid = (state == EMIT);
   assign digit_last  = digit_valid && (idx == '0);
   assign digit       = digit_valid ? bcd_reg[idx] : '0;
   assign done        = done_reg;
   assign xfer        = digit_valid && digit_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shift_reg <= '0;
         bcd_reg   <= '0;
         bit_cnt   <= '0;
         idx       <= '0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shift_reg <= id_in;
                  bcd_reg   <= '0;
                  bit_cnt   <= CNT_INIT;
                  state     <= CONVERT;
               end
            end
            CONVERT: begin
               bcd_reg   <= bcd_next;
               shift_reg <= shift_next;
               bit_cnt   <= bit_cnt - 1'b1;
               if (bit_cnt == CNT_W'(1)) begin
                  state <= EMIT;
                  idx   <= idx_entry;
               end
            end
            EMIT: begin
               if (xfer) begin
                  if (idx == '0) begin
                     state    <= IDLE;
                     done_reg <= 1'b1;
                  end else begin
                     idx <= idx - 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
